cdm8_err_stats: RTL and testbench

Error-statistics accumulator that sits directly downstream of the 8x8 carry-disregard approximate multiplier. It consumes a stream of operand pairs with the approximate product, recomputes the exact product, and accumulates error metrics over a fixed-length run. Results are the sample count, the erroneous-sample count, the sum of error distances and the worst case. These drive ER/MED/WCE characterisation in hardware, replacing file dumps.

---
 rtl/cdm8_err_stats_pkg.sv | 14 +
 rtl/cdm_ed_unit.sv | 57 +++++
 rtl/cdm8_err_stats.sv | 102 ++++++++++
 tb/tb_cdm8_err_stats.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdm8_err_stats_pkg.sv
// Shared widths and FSM encoding for the carry-disregard multiplier error-statistics block.
package cdm_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 17;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/cdm_ed_unit.sv
// Two registered stages: capture a/b/r, then exact product and |exact - r|.
module cdm_ed_unit
    import cdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [PROD_W-1:0] r,
    output logic              out_valid,
    output logic [PROD_W-1:0] ed,
    output logic [OP_W-1:0]   ed_a,
    output logic [OP_W-1:0]   ed_b,
    output logic              s0_busy
);
    localparam int STAGES = 2;

    logic [STAGES:1]     vld_pipe;
    logic [OP_W-1:0]     s0_a, s0_b;
    logic [PROD_W-1:0]   s0_r;
    logic [PROD_W-1:0]   prod;
    logic signed [PROD_W:0] diff;
    logic [PROD_W-1:0]   mag;

    assign prod = PROD_W'(s0_a) * PROD_W'(s0_b);
    // r may exceed 255*255, so the difference needs the extra sign bit.
    assign diff = $signed({1'b0, prod}) - $signed({1'b0, s0_r});
    assign mag  = diff[PROD_W] ? PROD_W'(-diff) : diff[PROD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_r     <= '0;
            ed       <= '0;
            ed_a     <= '0;
            ed_b     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid) begin
                s0_a <= a;
                s0_b <= b;
                s0_r <= r;
            end
            if (vld_pipe[1]) begin
                ed   <= mag;
                ed_a <= s0_a;
                ed_b <= s0_b;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign s0_busy   = vld_pipe[1];
endmodule

// File: rtl/cdm8_err_stats.sv
// Run-length FSM, accept counter and error accumulators (ER/MED/WCE source data).
module cdm8_err_stats
    import cdm_pkg::*;
#(
    parameter int N_SAMPLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [PROD_W-1:0] r,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [PROD_W-1:0] max_ed,
    output logic [OP_W-1:0]   max_a,
    output logic [OP_W-1:0]   max_b
);
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   acc_cnt;
    logic               accept, last_acc, start_ok;
    logic               ed_vld, s0_busy;
    logic [PROD_W-1:0]  ed;
    logic [OP_W-1:0]    ed_a, ed_b;

    // acc_cnt < N_SAMPLES always holds in RUN since the last accept leaves RUN.
    assign in_ready = (state == ST_RUN);
    assign accept   = in_valid & in_ready;
    assign last_acc = (acc_cnt == CNT_W'(N_SAMPLES - 1));
    assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign busy     = (state == ST_RUN) | (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)            state_nxt = ST_RUN;
            ST_RUN:           if (accept && last_acc) state_nxt = ST_DRAIN;
            // Leaving when stage 0 is empty lines DONE up with the final accumulate.
            ST_DRAIN:         if (!s0_busy)         state_nxt = ST_DONE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok)    acc_cnt <= '0;
            else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    cdm_ed_unit u_ed (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .a         (a),
        .b         (b),
        .r         (r),
        .out_valid (ed_vld),
        .ed        (ed),
        .ed_a      (ed_a),
        .ed_b      (ed_b),
        .s0_busy   (s0_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (ed_vld) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ed != '0) err_cnt <= err_cnt + CNT_W'(1);
            sum_ed <= sum_ed + ACC_W'(ed);
            // Strict compare: first sample reaching the maximum keeps its operands.
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= ed_a;
                max_b  <= ed_b;
            end
        end
    end
endmodule

// File: tb/tb_cdm8_err_stats.sv
// Directed bench for cdm8_err_stats: a 4-sample instance and a 128-sample instance.
module tb_cdm8_err_stats;
    logic        clk = 1'b0;
    logic        rst_4 = 1'b1, rst_128 = 1'b1;
    logic        start_4 = 1'b0, start_128 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [15:0] r = '0;

    logic        in_ready_4, busy_4, done_4;
    logic [16:0] sample_cnt_4, err_cnt_4;
    logic [31:0] sum_ed_4;
    logic [15:0] max_ed_4;
    logic [7:0]  max_a_4, max_b_4;

    logic        in_ready_128, busy_128, done_128;
    logic [16:0] sample_cnt_128, err_cnt_128;
    logic [31:0] sum_ed_128;
    logic [15:0] max_ed_128;
    logic [7:0]  max_a_128, max_b_128;

    int n_chk = 0, n_fail = 0;
    logic sel = 1'b0;   // 0: 4-sample instance, 1: 128-sample instance
    int m_cnt, m_err, m_sum, m_max, m_ma, m_mb;

    always #5 clk = ~clk;

    cdm8_err_stats #(.N_SAMPLES(4)) u_dut4 (
        .clk(clk), .rst(rst_4), .start(start_4), .in_valid(in_valid), .in_ready(in_ready_4),
        .a(a), .b(b), .r(r), .busy(busy_4), .done(done_4), .sample_cnt(sample_cnt_4),
        .err_cnt(err_cnt_4), .sum_ed(sum_ed_4), .max_ed(max_ed_4), .max_a(max_a_4), .max_b(max_b_4)
    );

    cdm8_err_stats #(.N_SAMPLES(128)) u_dut128 (
        .clk(clk), .rst(rst_128), .start(start_128), .in_valid(in_valid), .in_ready(in_ready_128),
        .a(a), .b(b), .r(r), .busy(busy_128), .done(done_128), .sample_cnt(sample_cnt_128),
        .err_cnt(err_cnt_128), .sum_ed(sum_ed_128), .max_ed(max_ed_128), .max_a(max_a_128), .max_b(max_b_128)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_ed(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] rr);
        int e;
        e = int'(aa) * int'(bb) - int'(rr);
        return (e < 0) ? -e : e;
    endfunction

    task automatic model_clr();
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        if (sel) start_128 = 1'b1; else start_4 = 1'b1;
        tick();
        start_4 = 1'b0; start_128 = 1'b0;
    endtask

    // Holds the sample until the selected instance accepts it; returns #1 after the accept edge.
    task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] rr);
        int guard, e;
        a = aa; b = bb; r = rr; in_valid = 1'b1;
        guard = 0;
        while (!(sel ? in_ready_128 : in_ready_4)) begin
            tick();
            guard++;
            if (guard > 50) begin
                check("accept_timeout", 32'(guard), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        tick();
        in_valid = 1'b0;
        e = ref_ed(aa, bb, rr);
        m_cnt++; m_sum += e;
        if (e != 0) m_err++;
        if (e > m_max) begin m_max = e; m_ma = aa; m_mb = bb; end
    endtask

    task automatic check_stats(input string tag);
        if (sel) begin
            check({tag, ".cnt"},  32'(sample_cnt_128), 32'(m_cnt));
            check({tag, ".err"},  32'(err_cnt_128),    32'(m_err));
            check({tag, ".sum"},  sum_ed_128,          32'(m_sum));
            check({tag, ".max"},  32'(max_ed_128),     32'(m_max));
            check({tag, ".maxa"}, 32'(max_a_128),      32'(m_ma));
            check({tag, ".maxb"}, 32'(max_b_128),      32'(m_mb));
        end else begin
            check({tag, ".cnt"},  32'(sample_cnt_4), 32'(m_cnt));
            check({tag, ".err"},  32'(err_cnt_4),    32'(m_err));
            check({tag, ".sum"},  sum_ed_4,          32'(m_sum));
            check({tag, ".max"},  32'(max_ed_4),     32'(m_max));
            check({tag, ".maxa"}, 32'(max_a_4),      32'(m_ma));
            check({tag, ".maxb"}, 32'(max_b_4),      32'(m_mb));
        end
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!(sel ? done_128 : done_4) && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, ".done"}, 32'(sel ? done_128 : done_4), 32'd1);
    endtask

    initial begin
        // Reset with junk on the inputs
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
            in_valid = 1'($urandom); start_4 = 1'($urandom); start_128 = 1'($urandom);
            tick();
        end
        check("rst.ready4", 32'(in_ready_4), 32'd0);
        check("rst.busy4",  32'(busy_4),     32'd0);
        check("rst.done4",  32'(done_4),     32'd0);
        check("rst.all4",   32'({sample_cnt_4, err_cnt_4} | 34'(sum_ed_4) | 34'({max_ed_4, max_a_4, max_b_4})), 32'd0);
        check("rst.all128", 32'({in_ready_128, busy_128, done_128, sample_cnt_128, err_cnt_128}) | sum_ed_128, 32'd0);
        in_valid = 1'b0; start_4 = 1'b0; start_128 = 1'b0;
        rst_4 = 1'b0; rst_128 = 1'b0;
        tick();

        // Short run
        sel = 1'b0; model_clr();
        do_start();
        check("start.ready", 32'(in_ready_4), 32'd1);
        check("start.busy",  32'(busy_4),     32'd1);
        send(8'd3, 8'd5, 16'd15);
        send(8'd10, 8'd10, 16'd100);
        send(8'd255, 8'd255, 16'd64000);
        send(8'd7, 8'd9, 16'd60);
        check("short.ready_drop", 32'(in_ready_4), 32'd0);
        check("short.done_k",     32'(done_4),     32'd0);
        tick();
        check("short.done_k1",    32'(done_4),     32'd0);
        check("short.busy_k1",    32'(busy_4),     32'd1);
        tick();
        check("short.done_k2",    32'(done_4),     32'd1);
        check("short.busy_k2",    32'(busy_4),     32'd0);
        check("short.cnt",  32'(sample_cnt_4), 32'd4);
        check("short.err",  32'(err_cnt_4),    32'd2);
        check("short.sum",  sum_ed_4,          32'd1028);
        check("short.max",  32'(max_ed_4),     32'd1025);
        check("short.maxa", 32'(max_a_4),      32'd255);
        check("short.maxb", 32'(max_b_4),      32'd255);

        // r above exact; the trailing exact sample must not disturb anything
        for (int pass = 0; pass < 2; pass++) begin
            model_clr(); do_start();
            if (pass == 0) begin send(8'd2, 8'd2, 16'd6); send(8'd1, 8'd1, 16'd3); end
            else           begin send(8'd1, 8'd1, 16'd3); send(8'd2, 8'd2, 16'd6); end
            send(8'd0, 8'd0, 16'd65535);
            send(8'd1, 8'd1, 16'd1);
            wait_done("hi");
            check("hi.max", 32'(max_ed_4), 32'd65535);
            check("hi.sum", sum_ed_4,      32'd65539);
            check_stats("hi");
        end

        // Ties: first occurrence of the maximum keeps its operands
        model_clr(); do_start();
        send(8'd2, 8'd2, 16'd6); send(8'd3, 8'd3, 16'd7);
        send(8'd1, 8'd1, 16'd1); send(8'd1, 8'd1, 16'd1);
        wait_done("tie1");
        check("tie1.maxa", 32'(max_a_4), 32'd2);
        check_stats("tie1");
        model_clr(); do_start();
        send(8'd3, 8'd3, 16'd7); send(8'd2, 8'd2, 16'd6);
        send(8'd1, 8'd1, 16'd1); send(8'd1, 8'd1, 16'd1);
        wait_done("tie2");
        check("tie2.maxa", 32'(max_a_4), 32'd3);
        check_stats("tie2");

        // Backpressure and bubbles on the 128-sample instance
        sel = 1'b1; model_clr(); do_start();
        for (int i = 0; i < 128; i++) begin
            logic [7:0] ra, rb;
            logic [15:0] rr;
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                a = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
                tick();
            end
            ra = 8'($urandom); rb = 8'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 16'(ra) * 16'(rb) : 16'($urandom);
            send(ra, rb, rr);
        end
        check("bp.ready_drop", 32'(in_ready_128), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_done("bp");
        check_stats("bp");
        check("bp.cnt128", 32'(sample_cnt_128), 32'd128);

        // Reset mid-run after 100 accepts, then a fresh partial run
        model_clr(); do_start();
        for (int i = 0; i < 100; i++) send(8'(i + 1), 8'd200, 16'd3);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; r = 16'd0;
        rst_128 = 1'b1;
        #2;
        check("mid.rst_cnt",  32'(sample_cnt_128), 32'd0);
        check("mid.rst_busy", 32'(busy_128),       32'd0);
        check("mid.rst_max",  32'(max_ed_128),     32'd0);
        rst_128 = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("mid.idle_ready", 32'(in_ready_128), 32'd0);
        model_clr(); do_start();
        send(8'd3, 8'd5, 16'd15);
        send(8'd10, 8'd10, 16'd100);
        send(8'd255, 8'd255, 16'd64000);
        send(8'd7, 8'd9, 16'd60);
        tick(); tick();
        check_stats("mid");
        check("mid.sum", sum_ed_128, 32'd1028);
        check("mid.busy", 32'(busy_128), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
